// File: rtl/ws_chain_if.sv
// ws_chain_if - bundle for the LED chain stream monitor path.
//
// Signals:
//   din           serial chain line (asynchronous to the decoder clock)
//   word          last decoded pixel word, MSB = first bit received
//   word_valid    one-cycle pulse when word updates
//   pixel_idx     index of the word in word within the current frame
//   frame_end     one-cycle pulse on latch-gap detection
//   frame_pixels  complete words in the frame that just ended
//   err_glitch    one-cycle pulse, high pulse too short to be a bit
//   err_stuck     one-cycle pulse, line held high too long
//   err_partial   one-cycle pulse, frame closed with a partial word pending
//
// Modports:
//   master  decoder side (samples din, drives the results)
//   slave   line source / consumer side
interface ws_chain_if #(
   parameter int unsigned WORD_W = 24,
   parameter int unsigned IDX_W  = 16
) ();

   logic              din;
   logic [WORD_W-1:0] word;
   logic              word_valid;
   logic [IDX_W-1:0]  pixel_idx;
   logic              frame_end;
   logic [IDX_W-1:0]  frame_pixels;
   logic              err_glitch;
   logic              err_stuck;
   logic              err_partial;

   modport master (
      input  din,
      output word,
      output word_valid,
      output pixel_idx,
      output frame_end,
      output frame_pixels,
      output err_glitch,
      output err_stuck,
      output err_partial
   );

   modport slave (
      output din,
      input  word,
      input  word_valid,
      input  pixel_idx,
      input  frame_end,
      input  frame_pixels,
      input  err_glitch,
      input  err_stuck,
      input  err_partial
   );

endinterface

// File: rtl/ws_chain_decoder.sv
// ws_chain_decoder - receiver for the single-wire pulse-width LED chain stream.
//
// Each bit is one high pulse followed by low time; a high pulse of THRESH cycles
// or more is a 1. Bits are assembled MSB-first into WORD_W-bit pixel words,
// pixels are counted per frame, and a low gap of RESET_LOW cycles closes the
// frame.
//
// Ports:
//   clk    sole clock, rising edge
//   rst    asynchronous, active-high reset
//   chain  ws_chain_if.master: din in; word, word_valid, pixel_idx, frame_end,
//          frame_pixels, err_glitch, err_stuck, err_partial out
//
// All outputs are registered. Pulse widths are measured on the synchronized
// line, which is din delayed by two clk cycles, so widths on din are preserved.
module ws_chain_decoder #(
   parameter int unsigned WORD_W    = 24,
   parameter int unsigned THRESH    = 7,
   parameter int unsigned MIN_HIGH  = 2,
   parameter int unsigned MAX_HIGH  = 13,
   parameter int unsigned RESET_LOW = 64,
   parameter int unsigned IDX_W     = 16
) (
   input logic        clk,
   input logic        rst,
   ws_chain_if.master chain
);

   localparam int unsigned HCNT_W = $clog2(MAX_HIGH + 1);
   localparam int unsigned LCNT_W = $clog2(RESET_LOW + 1);
   localparam int unsigned BCNT_W = $clog2(WORD_W + 1);

   localparam logic [HCNT_W-1:0] HCNT_ONE   = HCNT_W'(1);
   localparam logic [HCNT_W-1:0] HCNT_STUCK = HCNT_W'(MAX_HIGH - 1);
   localparam logic [HCNT_W-1:0] HCNT_MAX   = HCNT_W'(MAX_HIGH);
   localparam logic [HCNT_W-1:0] HCNT_MIN   = HCNT_W'(MIN_HIGH);
   localparam logic [HCNT_W-1:0] HCNT_THR   = HCNT_W'(THRESH);
   localparam logic [LCNT_W-1:0] LCNT_ONE   = LCNT_W'(1);
   localparam logic [LCNT_W-1:0] LCNT_GAP   = LCNT_W'(RESET_LOW - 1);
   localparam logic [BCNT_W-1:0] BCNT_ONE   = BCNT_W'(1);
   localparam logic [BCNT_W-1:0] BCNT_FULL  = BCNT_W'(WORD_W);
   localparam logic [IDX_W-1:0]  PCNT_ONE   = IDX_W'(1);

   typedef enum logic [1:0] {
      StIdle,
      StHigh,
      StLow,
      StStuck
   } state_e;

   // Two-flop synchronizer; line_q is the line every width is measured on.
   logic sync1_q;
   logic line_q;

   state_e              state_q, state_d;
   logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
   logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
   logic [WORD_W-1:0]   shift_q, shift_d;
   logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
   logic [IDX_W-1:0]    pcnt_q, pcnt_d;

   logic [WORD_W-1:0]   word_q, word_d;
   logic                word_valid_q, word_valid_d;
   logic [IDX_W-1:0]    pixel_idx_q, pixel_idx_d;
   logic                frame_end_q, frame_end_d;
   logic [IDX_W-1:0]    frame_pixels_q, frame_pixels_d;
   logic                err_glitch_q, err_glitch_d;
   logic                err_stuck_q, err_stuck_d;
   logic                err_partial_q, err_partial_d;

   logic                close_frame;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q        <= 1'b0;
         line_q         <= 1'b0;
         state_q        <= StIdle;
         hcnt_q         <= '0;
         lcnt_q         <= '0;
         shift_q        <= '0;
         bcnt_q         <= '0;
         pcnt_q         <= '0;
         word_q         <= '0;
         word_valid_q   <= 1'b0;
         pixel_idx_q    <= '0;
         frame_end_q    <= 1'b0;
         frame_pixels_q <= '0;
         err_glitch_q   <= 1'b0;
         err_stuck_q    <= 1'b0;
         err_partial_q  <= 1'b0;
      end else begin
         sync1_q        <= chain.din;
         line_q         <= sync1_q;
         state_q        <= state_d;
         hcnt_q         <= hcnt_d;
         lcnt_q         <= lcnt_d;
         shift_q        <= shift_d;
         bcnt_q         <= bcnt_d;
         pcnt_q         <= pcnt_d;
         word_q         <= word_d;
         word_valid_q   <= word_valid_d;
         pixel_idx_q    <= pixel_idx_d;
         frame_end_q    <= frame_end_d;
         frame_pixels_q <= frame_pixels_d;
         err_glitch_q   <= err_glitch_d;
         err_stuck_q    <= err_stuck_d;
         err_partial_q  <= err_partial_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      hcnt_d         = hcnt_q;
      lcnt_d         = lcnt_q;
      shift_d        = shift_q;
      bcnt_d         = bcnt_q;
      pcnt_d         = pcnt_q;
      word_d         = word_q;
      word_valid_d   = 1'b0;
      pixel_idx_d    = pixel_idx_q;
      frame_end_d    = 1'b0;
      frame_pixels_d = frame_pixels_q;
      err_glitch_d   = 1'b0;
      err_stuck_d    = 1'b0;
      err_partial_d  = 1'b0;
      close_frame    = 1'b0;

      // A full word is published one update after its last bit lands. The FSM
      // is then in LOW or just re-entered HIGH, so no bit decode, stuck or
      // frame close can collide with this update.
      if (bcnt_q == BCNT_FULL) begin
         word_d       = shift_q;
         word_valid_d = 1'b1;
         pixel_idx_d  = pcnt_q;
         bcnt_d       = '0;
         if (pcnt_q != '1) begin
            pcnt_d = pcnt_q + PCNT_ONE;
         end
      end

      unique case (state_q)
         StIdle: begin
            if (line_q) begin
               state_d = StHigh;
               hcnt_d  = HCNT_ONE;
            end
         end

         StHigh: begin
            if (line_q) begin
               if (hcnt_q >= HCNT_STUCK) begin
                  // Width has just reached MAX_HIGH: drop the partial word but
                  // keep the pixel count, then wait for a full latch gap.
                  err_stuck_d = 1'b1;
                  hcnt_d      = HCNT_MAX;
                  lcnt_d      = '0;
                  shift_d     = '0;
                  bcnt_d      = '0;
                  state_d     = StStuck;
               end else begin
                  hcnt_d = hcnt_q + HCNT_ONE;
               end
            end else begin
               state_d = StLow;
               lcnt_d  = LCNT_ONE;
               if (hcnt_q < HCNT_MIN) begin
                  err_glitch_d = 1'b1;
               end else begin
                  shift_d = {shift_q[WORD_W-2:0], (hcnt_q >= HCNT_THR)};
                  bcnt_d  = bcnt_q + BCNT_ONE;
               end
            end
         end

         StLow: begin
            if (line_q) begin
               state_d = StHigh;
               hcnt_d  = HCNT_ONE;
            end else if (lcnt_q >= LCNT_GAP) begin
               close_frame = 1'b1;
            end else begin
               lcnt_d = lcnt_q + LCNT_ONE;
            end
         end

         StStuck: begin
            // Any high before the gap completes restarts the gap count.
            if (line_q) begin
               lcnt_d = '0;
            end else if (lcnt_q >= LCNT_GAP) begin
               close_frame = 1'b1;
            end else begin
               lcnt_d = lcnt_q + LCNT_ONE;
            end
         end
      endcase

      if (close_frame) begin
         frame_end_d    = 1'b1;
         frame_pixels_d = pcnt_q;
         // After a stuck-high the partial word was already reported and dropped.
         err_partial_d  = (state_q == StLow) && (bcnt_q != '0);
         bcnt_d         = '0;
         shift_d        = '0;
         pcnt_d         = '0;
         hcnt_d         = '0;
         lcnt_d         = '0;
         state_d        = StIdle;
      end
   end

   assign chain.word         = word_q;
   assign chain.word_valid   = word_valid_q;
   assign chain.pixel_idx    = pixel_idx_q;
   assign chain.frame_end    = frame_end_q;
   assign chain.frame_pixels = frame_pixels_q;
   assign chain.err_glitch   = err_glitch_q;
   assign chain.err_stuck    = err_stuck_q;
   assign chain.err_partial  = err_partial_q;

endmodule

// File: tb/tb_ws_chain_decoder.sv
// Bench for ws_chain_decoder. The line is described as a list of (level, width)
// segments; a reference model turns that list into the expected sequence of
// word / frame / error events, which is compared against events captured from
// the DUT outputs.
module tb_ws_chain_decoder;

   localparam int WORD_W    = 24;
   localparam int IDX_W     = 16;
   localparam int THRESH    = 7;
   localparam int MIN_HIGH  = 2;
   localparam int MAX_HIGH  = 13;
   localparam int RESET_LOW = 64;

   // Event kinds
   localparam int EvWord    = 0;
   localparam int EvFrame   = 1;
   localparam int EvGlitch  = 2;
   localparam int EvStuck   = 3;
   localparam int EvOrphan  = 4;

   typedef struct {
      bit lvl;
      int w;
   } seg_t;

   typedef struct {
      logic [23:0] data;
      int          h1;
      int          l1;
      int          h0;
      int          l0;
      logic [23:0] exp_word;
   } vec_t;

   logic clk;
   logic rst;

   int errors = 0;
   int checks = 0;

   seg_t        sq[$];
   logic [95:0] dut_ev[$];
   logic [95:0] exp_ev[$];

   ws_chain_if #(.WORD_W(WORD_W), .IDX_W(IDX_W)) chain ();

   ws_chain_decoder #(
      .WORD_W   (WORD_W),
      .THRESH   (THRESH),
      .MIN_HIGH (MIN_HIGH),
      .MAX_HIGH (MAX_HIGH),
      .RESET_LOW(RESET_LOW),
      .IDX_W    (IDX_W)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .chain(chain)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [95:0] mk_ev(input int kind, input int a, input int b);
      return {32'(kind), 32'(a), 32'(b)};
   endfunction

   // Capture DUT pulses as events, sampled away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         if (chain.word_valid)
            dut_ev.push_back(mk_ev(EvWord, int'(chain.word), int'(chain.pixel_idx)));
         if (chain.frame_end)
            dut_ev.push_back(mk_ev(EvFrame, int'(chain.frame_pixels), int'(chain.err_partial)));
         if (chain.err_partial && !chain.frame_end)
            dut_ev.push_back(mk_ev(EvOrphan, 0, 0));
         if (chain.err_glitch)
            dut_ev.push_back(mk_ev(EvGlitch, 0, 0));
         if (chain.err_stuck)
            dut_ev.push_back(mk_ev(EvStuck, 0, 0));
      end
   end

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   // Reference model: walks whole pulses, not cycles.
   function automatic void run_model();
      bit          idle  = 1'b1;
      bit          stuck = 1'b0;
      int          bits  = 0;
      int          pcnt  = 0;
      logic [23:0] acc   = '0;
      foreach (sq[i]) begin
         if (sq[i].lvl) begin
            if (!stuck) begin
               idle = 1'b0;
               if (sq[i].w >= MAX_HIGH) begin
                  exp_ev.push_back(mk_ev(EvStuck, 0, 0));
                  stuck = 1'b1;
                  bits  = 0;
               end else if (sq[i].w < MIN_HIGH) begin
                  exp_ev.push_back(mk_ev(EvGlitch, 0, 0));
               end else begin
                  acc = {acc[22:0], (sq[i].w >= THRESH)};
                  bits++;
                  if (bits == WORD_W) begin
                     exp_ev.push_back(mk_ev(EvWord, int'(acc), pcnt));
                     if (pcnt < 65535) pcnt++;
                     bits = 0;
                  end
               end
            end
         end else if (!idle && sq[i].w >= RESET_LOW) begin
            exp_ev.push_back(mk_ev(EvFrame, pcnt, int'(!stuck && bits != 0)));
            idle  = 1'b1;
            stuck = 1'b0;
            bits  = 0;
            pcnt  = 0;
         end
      end
   endfunction

   function automatic void add_seg(input bit lvl, input int n);
      seg_t t;
      if (sq.size() > 0 && sq[sq.size()-1].lvl == lvl) begin
         t = sq.pop_back();
         t.w += n;
      end else begin
         t.lvl = lvl;
         t.w   = n;
      end
      sq.push_back(t);
   endfunction

   task automatic seg(input bit lvl, input int n);
      add_seg(lvl, n);
      chain.din = lvl;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [23:0] data, input int nbits,
                            input int h1, input int l1, input int h0, input int l0);
      logic b;
      for (int i = 23; i > 23 - nbits; i--) begin
         b = data[i];
         seg(1'b1, b ? h1 : h0);
         seg(1'b0, b ? l1 : l0);
      end
   endtask

   task automatic send_word(input logic [23:0] data, input int h1, input int l1,
                            input int h0, input int l0, input int last_low);
      send_bits(data, 23, h1, l1, h0, l0);
      seg(1'b1, data[0] ? h1 : h0);
      seg(1'b0, last_low);
   endtask

   task automatic check_events(input string tag);
      int n;
      run_model();
      chk({tag, " event count"}, 96'(dut_ev.size()), 96'(exp_ev.size()));
      n = (dut_ev.size() < exp_ev.size()) ? dut_ev.size() : exp_ev.size();
      for (int i = 0; i < n; i++)
         chk($sformatf("%s event %0d", tag, i), dut_ev[i], exp_ev[i]);
      sq.delete();
      dut_ev.delete();
      exp_ev.delete();
   endtask

   task automatic check_zero(input string tag);
      chk({tag, " word"},         96'(chain.word),         96'(0));
      chk({tag, " word_valid"},   96'(chain.word_valid),   96'(0));
      chk({tag, " pixel_idx"},    96'(chain.pixel_idx),    96'(0));
      chk({tag, " frame_end"},    96'(chain.frame_end),    96'(0));
      chk({tag, " frame_pixels"}, 96'(chain.frame_pixels), 96'(0));
      chk({tag, " err_glitch"},   96'(chain.err_glitch),   96'(0));
      chk({tag, " err_stuck"},    96'(chain.err_stuck),    96'(0));
      chk({tag, " err_partial"},  96'(chain.err_partial),  96'(0));
   endtask

   task automatic do_reset(input string tag);
      check_events(tag);
      chain.din = 1'b0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   vec_t vecs[7];

   initial begin
      int w;
      int r;

      vecs[0] = '{24'h123456, 9, 7,  5, 11, 24'h123456};
      vecs[1] = '{24'hABCDEF, 9, 7,  5, 11, 24'hABCDEF};
      vecs[2] = '{24'h000001, 9, 7,  5, 11, 24'h000001};
      vecs[3] = '{24'hF0F0F0, 7, 63, 6, 63, 24'hF0F0F0};
      vecs[4] = '{24'h0F0F0F, 12, 1, 2, 3,  24'h0F0F0F};
      vecs[5] = '{24'hFFFFFF, 6, 7,  5, 11, 24'h000000};
      vecs[6] = '{24'h000000, 9, 7,  7, 11, 24'hFFFFFF};

      rst = 1'b0;
      chain.din = 1'b0;
      #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // Single word FF0000 with an exact word_valid latency check on the last bit.
      send_bits(24'hFF0000, 23, 9, 7, 5, 11);
      seg(1'b1, 5);
      add_seg(1'b0, 80);
      chain.din = 1'b0;
      for (int k = 1; k <= 5; k++) begin
         @(negedge clk);
         chk($sformatf("latency word_valid n%0d", k), 96'(chain.word_valid), 96'(k == 4));
      end
      repeat (75) @(negedge clk);
      chk("single word", 96'(chain.word), 96'(24'hFF0000));
      chk("single idx", 96'(chain.pixel_idx), 96'(0));
      do_reset("single");

      // Table: one frame of several words, including width and gap boundaries.
      for (int i = 0; i < 7; i++) begin
         send_word(vecs[i].data, vecs[i].h1, vecs[i].l1, vecs[i].h0, vecs[i].l0, 6);
         chk($sformatf("table word %0d", i), 96'(chain.word), 96'(vecs[i].exp_word));
         chk($sformatf("table idx %0d", i), 96'(chain.pixel_idx), 96'(i));
      end
      seg(1'b0, 80);
      chk("table frame_pixels", 96'(chain.frame_pixels), 96'(7));
      do_reset("table");

      // Glitch between bits 5 and 6.
      for (int i = 23; i >= 0; i--) begin
         seg(1'b1, (24'hA5A5A5 >> i) & 1 ? 9 : 5);
         seg(1'b0, (24'hA5A5A5 >> i) & 1 ? 7 : 11);
         if (i == 18) begin
            seg(1'b1, 1);
            seg(1'b0, 7);
         end
      end
      seg(1'b0, 80);
      chk("glitch word", 96'(chain.word), 96'(24'hA5A5A5));
      do_reset("glitch");

      // Stuck high mid-word, then recovery.
      send_bits(24'h123456, 10, 9, 7, 5, 11);
      seg(1'b1, 20);
      seg(1'b0, 64);
      send_word(24'h00FF00, 9, 7, 5, 11, 80);
      chk("stuck word", 96'(chain.word), 96'(24'h00FF00));
      chk("stuck idx", 96'(chain.pixel_idx), 96'(0));
      do_reset("stuck");

      // Partial word at frame end.
      send_bits(24'hC0FFEE, 10, 9, 7, 5, 11);
      seg(1'b0, 64);
      seg(1'b0, 10);
      do_reset("partial");

      // Reset in the middle of a word.
      send_word(24'hC3C3C3, 9, 7, 5, 11, 6);
      chk("pre-reset word", 96'(chain.word), 96'(24'hC3C3C3));
      send_bits(24'h5A5A5A, 12, 9, 7, 5, 11);
      check_events("pre-reset");
      chain.din = 1'b0;
      rst = 1'b1;
      #1;
      check_zero("mid reset");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send_word(24'h5A5A5A, 9, 7, 5, 11, 6);
      chk("post-reset word", 96'(chain.word), 96'(24'h5A5A5A));
      chk("post-reset idx", 96'(chain.pixel_idx), 96'(0));
      seg(1'b0, 80);
      chk("post-reset frame_pixels", 96'(chain.frame_pixels), 96'(1));
      do_reset("post-reset");

      // Random pulse trains.
      for (int s = 0; s < 4; s++) begin
         for (int n = 0; n < 250; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 90)      w = int'($urandom_range(2, 12));
            else if (r < 96) w = 1;
            else if (r < 98) w = int'($urandom_range(13, 20));
            else             w = int'($urandom_range(5, 9));
            seg(1'b1, w);
            r = int'($urandom_range(0, 99));
            if (r < 90)      w = int'($urandom_range(1, 20));
            else if (r < 98) w = int'($urandom_range(55, 63));
            else             w = int'($urandom_range(64, 90));
            seg(1'b0, w);
         end
         seg(1'b0, 80);
         do_reset($sformatf("random %0d", s));
      end

      check_events("final");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
